// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: constants and the fetch tuple shared by fetch, fetch_queue and decode.
package fetch_queue_pkg;
  localparam int DATA_WID = 32;
  localparam logic [DATA_WID-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [DATA_WID-1:0] pc;
    logic [DATA_WID-1:0] inst;
    logic                pred;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch-to-decode buffer with valid/ready handshake and flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_WID = fetch_queue_pkg::DATA_WID,
  parameter logic [DATA_WID-1:0] NOP_INST = DATA_WID'(fetch_queue_pkg::NOP_INST)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WID-1:0]        in_pc,
  input  logic [DATA_WID-1:0]        in_inst,
  input  logic                       in_pred,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [DATA_WID-1:0]        out_pc,
  output logic [DATA_WID-1:0]        out_inst,
  output logic                       out_pred,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WID-1:0] pc_mem_q [DEPTH];
  logic [DATA_WID-1:0] inst_mem_q [DEPTH];
  logic                pred_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic enq, deq;
  // Ready/valid come only from the registered count, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = count_q != CW'(DEPTH);
    out_valid = count_q != '0;
    enq       = in_valid && in_ready && !flush;
    deq       = out_valid && out_ready && !flush;
    wr_ptr_d  = flush ? '0 : wr_ptr_q + AW'(enq);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + AW'(deq);
    count_d   = flush ? '0 : count_q + CW'(enq) - CW'(deq);
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
    out_pred  = out_valid ? pred_mem_q[rd_ptr_q] : 1'b0;
    count     = count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (enq) begin
        pc_mem_q[wr_ptr_q]   <= in_pc;
        inst_mem_q[wr_ptr_q] <= in_inst;
        pred_mem_q[wr_ptr_q] <= in_pred;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus random stimulus against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_pred, out_ready;
  logic [31:0] in_pc, in_inst;
  logic in_ready, out_valid, out_pred;
  logic [31:0] out_pc, out_inst;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;
  fetch_entry_t mq[$];
  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_pred(in_pred), .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_pred(out_pred), .out_ready(out_ready),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  task automatic check_all(input string tag);
    logic [1:0] diff;
    int n;
    n = mq.size();
    chk({tag, ":count"}, 32'(count), 32'(n));
    chk({tag, ":in_ready"}, 32'(in_ready), 32'(n != DEPTH));
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(n != 0));
    chk({tag, ":out_pc"}, out_pc, n != 0 ? mq[0].pc : 32'h0);
    chk({tag, ":out_inst"}, out_inst, n != 0 ? mq[0].inst : NOP_INST);
    chk({tag, ":out_pred"}, 32'(out_pred), 32'(n != 0 ? mq[0].pred : 1'b0));
    diff = dut.wr_ptr_q - dut.rd_ptr_q;
    chk({tag, ":ptr_inv"}, 32'(count == 3'(DEPTH) ? diff == 2'd0 : count == {1'b0, diff}), 32'd1);
  endtask
  task automatic cyc(input string tag, input logic r, input logic f, input logic iv,
                     input logic [31:0] pc, input logic [31:0] inst, input logic p,
                     input logic ordy);
    bit do_enq, do_deq;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; in_pred = p; out_ready = ordy;
    @(posedge clk);
    if (r || f) mq.delete();
    else begin
      do_enq = iv && mq.size() < DEPTH;
      do_deq = ordy && mq.size() != 0;
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back('{pc: pc, inst: inst, pred: p});
    end
    @(negedge clk);
    check_all(tag);
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 1; in_pc = 0; in_inst = 0; in_pred = 0; out_ready = 0;
    cyc("reset0", 1, 0, 1, 32'h0000_0500, 32'h1111_1111, 1, 0);
    cyc("reset1", 1, 0, 1, 32'h0000_0500, 32'h1111_1111, 1, 0);
    chk("reset_nop", out_inst, 32'h0000_0013);
    cyc("basic_e0", 0, 0, 1, 32'h1000, 32'h0050_0093, 0, 0);
    cyc("basic_e1", 0, 0, 1, 32'h1004, 32'h0010_8113, 0, 0);
    cyc("basic_e2", 0, 0, 1, 32'h1008, 32'hFE00_0EE3, 1, 0);
    chk("basic_head", out_pc, 32'h1000);
    for (int i = 0; i < 3; i++) cyc("basic_pop", 0, 0, 0, 0, 0, 0, 1);
    chk("basic_empty", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++)
      cyc("full_fill", 0, 0, 1, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'(i), 0);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    cyc("full_hold", 0, 0, 1, 32'h3010, 32'hA000_0004, 0, 0);
    cyc("full_pop", 0, 0, 1, 32'h3010, 32'hA000_0004, 0, 1);
    chk("full_after_pop", 32'(count), 32'd3);
    cyc("full_late", 0, 0, 1, 32'h3010, 32'hA000_0004, 0, 0);
    cyc("flush_clr", 0, 1, 0, 0, 0, 0, 0);
    cyc("sim_e0", 0, 0, 1, 32'h4000, 32'hB000_0000, 0, 0);
    cyc("sim_e1", 0, 0, 1, 32'h4004, 32'hB000_0001, 1, 0);
    for (int i = 2; i < 8; i++)
      cyc("sim_enqdeq", 0, 0, 1, 32'h4000 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'(i), 1);
    chk("sim_count", 32'(count), 32'd2);
    cyc("fl_e", 0, 0, 1, 32'h5000, 32'hC000_0000, 0, 0);
    chk("fl_count3", 32'(count), 32'd3);
    cyc("flush_mid", 0, 1, 1, 32'h5004, 32'hDEAD_BEEF, 1, 1);
    chk("flush_nop", out_inst, 32'h0000_0013);
    for (int i = 0; i < 4; i++)
      cyc("rm_fill", 0, 0, 1, 32'h6000 + 32'(4 * i), 32'hE000_0000 + 32'(i), 0, 0);
    cyc("rst_flush", 1, 1, 1, 32'h6010, 32'hE000_0004, 1, 1);
    cyc("rm_enq", 0, 0, 1, 32'h2000, 32'h0000_0073, 1, 0);
    chk("rm_head", out_pc, 32'h2000);
    for (int i = 0; i < 400; i++)
      cyc("rand", $urandom_range(63) == 0, $urandom_range(15) == 0, 1'($urandom),
          $urandom, $urandom, 1'($urandom), $urandom_range(3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
